// File: rtl/scan_index_gen.sv
// Scan sequencer for multiplexed displays: steps idx through masked-in digits with dwell and blanking gap.
// All outputs registered (start is one cycle after run is sampled); no backpressure, run/digit_mask are levels.
module scan_index_gen #(
   parameter int IDX_W     = 3,
   parameter int DIV       = 50000,
   parameter int BLANK_CYC = 2
) (
   input  logic                    clk,
   input  logic                    rst_n,
   input  logic                    run,
   input  logic [(1<<IDX_W)-1:0]   digit_mask,
   output logic [IDX_W-1:0]        idx,
   output logic                    en,
   output logic                    frame_done
);

   localparam int N     = 1 << IDX_W;
   localparam int CNT_W = $clog2(DIV + 1);
   localparam int BLK_W = (BLANK_CYC > 0) ? $clog2(BLANK_CYC + 1) : 1;
   localparam logic [CNT_W-1:0] DWELL_LAST = CNT_W'(DIV - 1);
   localparam logic [BLK_W-1:0] GAP_LAST   = BLK_W'((BLANK_CYC > 0) ? BLANK_CYC - 1 : 0);

   typedef enum logic [1:0] {
      ST_IDLE,
      ST_SHOW,
      ST_BLANK
   } state_t;

   state_t            r_state, w_state_nxt;
   logic [IDX_W-1:0]  r_idx, w_idx_nxt;
   logic [CNT_W-1:0]  r_cnt, w_cnt_nxt;
   logic [BLK_W-1:0]  r_gap, w_gap_nxt;
   logic              r_en, w_en_nxt;
   logic              r_fd, w_fd_nxt;

   logic [IDX_W-1:0]  w_first_idx;
   logic [IDX_W-1:0]  w_step_idx;
   logic [IDX_W-1:0]  w_cand;
   logic              w_step_found;
   logic              w_mask_any;
   logic              w_advance;

   assign w_mask_any = |digit_mask;

   always_comb begin
      w_first_idx = '0;
      for (int i = N - 1; i >= 0; i--) begin
         if (digit_mask[i]) w_first_idx = IDX_W'(i);
      end
   end

   // Circular search from idx+1; the step of N lands back on idx, so the current digit is tried last.
   always_comb begin
      w_step_idx   = r_idx;
      w_step_found = 1'b0;
      w_cand       = '0;
      for (int i = 1; i <= N; i++) begin
         w_cand = r_idx + IDX_W'(i);
         if (!w_step_found && digit_mask[w_cand]) begin
            w_step_found = 1'b1;
            w_step_idx   = w_cand;
         end
      end
   end

   always_comb begin
      w_state_nxt = r_state;
      w_idx_nxt   = r_idx;
      w_cnt_nxt   = r_cnt;
      w_gap_nxt   = r_gap;
      w_fd_nxt    = 1'b0;
      w_advance   = 1'b0;

      if (!run) begin
         w_state_nxt = ST_IDLE;
         w_cnt_nxt   = '0;
         w_gap_nxt   = '0;
      end else begin
         case (r_state)
            ST_IDLE: begin
               if (w_mask_any) begin
                  w_state_nxt = ST_SHOW;
                  w_idx_nxt   = w_first_idx;
                  w_cnt_nxt   = '0;
               end
            end
            ST_SHOW: begin
               if (r_cnt == DWELL_LAST) begin
                  w_cnt_nxt = '0;
                  if (BLANK_CYC > 0) begin
                     w_state_nxt = ST_BLANK;
                     w_gap_nxt   = '0;
                  end else begin
                     w_advance = 1'b1;
                  end
               end else begin
                  w_cnt_nxt = r_cnt + CNT_W'(1);
               end
            end
            ST_BLANK: begin
               if (r_gap == GAP_LAST) begin
                  w_gap_nxt = '0;
                  w_advance = 1'b1;
               end else begin
                  w_gap_nxt = r_gap + BLK_W'(1);
               end
            end
            default: begin
               w_state_nxt = ST_IDLE;
            end
         endcase

         if (w_advance) begin
            if (w_mask_any) begin
               w_state_nxt = ST_SHOW;
               w_idx_nxt   = w_step_idx;
               w_fd_nxt    = (w_step_idx <= r_idx);
            end else begin
               w_state_nxt = ST_IDLE;
            end
         end
      end

      w_en_nxt = (w_state_nxt == ST_SHOW);
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         r_state <= ST_IDLE;
         r_idx   <= '0;
         r_cnt   <= '0;
         r_gap   <= '0;
         r_en    <= 1'b0;
         r_fd    <= 1'b0;
      end else begin
         r_state <= w_state_nxt;
         r_idx   <= w_idx_nxt;
         r_cnt   <= w_cnt_nxt;
         r_gap   <= w_gap_nxt;
         r_en    <= w_en_nxt;
         r_fd    <= w_fd_nxt;
      end
   end

   assign idx        = r_idx;
   assign en         = r_en;
   assign frame_done = r_fd;

endmodule

// File: tb/tb_scan_index_gen.sv
// Directed bench for scan_index_gen: dwell/blank instance (DIV=4, BLANK_CYC=2) and back-to-back instance (DIV=1, BLANK_CYC=0).
module tb_scan_index_gen;

   logic       clk = 1'b0;
   logic       rst_n;
   logic       run_a, run_b;
   logic [7:0] mask_a, mask_b;
   logic [2:0] idx_a, idx_b;
   logic       en_a, en_b, fd_a, fd_b;

   int checks   = 0;
   int failures = 0;

   always #5 clk = ~clk;

   scan_index_gen #(.IDX_W(3), .DIV(4), .BLANK_CYC(2)) dut_a (
      .clk        (clk),
      .rst_n      (rst_n),
      .run        (run_a),
      .digit_mask (mask_a),
      .idx        (idx_a),
      .en         (en_a),
      .frame_done (fd_a)
   );

   scan_index_gen #(.IDX_W(3), .DIV(1), .BLANK_CYC(0)) dut_b (
      .clk        (clk),
      .rst_n      (rst_n),
      .run        (run_b),
      .digit_mask (mask_b),
      .idx        (idx_b),
      .en         (en_b),
      .frame_done (fd_b)
   );

   // Per-digit visit list: seq holds one index per nibble (entry k at bits 4k+2:4k), fd bit k = frame_done on visit k.
   typedef struct packed {
      logic [7:0]  mask;
      logic [7:0]  nvis;
      logic [63:0] seq;
      logic [15:0] fd;
   } scan_vec_t;

   scan_vec_t vecs [5];

   task automatic chk(input string name, input logic [4:0] got, input logic [4:0] exp);
      checks++;
      if (got !== exp) begin
         failures++;
         $display("FAIL %s got {en,idx,fd}=%b required=%b", name, got, exp);
      end
   endtask

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   initial begin
      scan_vec_t  vv;
      logic [2:0] d;
      logic       f;

      vecs[0] = '{mask: 8'hFF, nvis: 8'd10, seq: 64'h10_7654_3210, fd: 16'h0100};
      vecs[1] = '{mask: 8'hA4, nvis: 8'd7,  seq: 64'h275_2752,     fd: 16'h0048};
      vecs[2] = '{mask: 8'h10, nvis: 8'd4,  seq: 64'h4444,         fd: 16'h000E};
      vecs[3] = '{mask: 8'h81, nvis: 8'd5,  seq: 64'h07070,        fd: 16'h0014};
      vecs[4] = '{mask: 8'h80, nvis: 8'd3,  seq: 64'h777,          fd: 16'h0006};

      rst_n  = 1'b0;
      run_a  = 1'b0;
      run_b  = 1'b0;
      mask_a = 8'h00;
      mask_b = 8'h00;
      #3;
      chk("reset_a", {en_a, idx_a, fd_a}, 5'b0);
      chk("reset_b", {en_b, idx_b, fd_b}, 5'b0);
      tick();
      rst_n = 1'b1;
      tick();
      chk("idle_after_reset_a", {en_a, idx_a, fd_a}, 5'b0);

      for (int v = 0; v < 5; v++) begin
         vv    = vecs[v];
         run_a = 1'b0;
         tick();
         chk($sformatf("v%0d_idle", v), {en_a, 3'b000, fd_a}, 5'b0);
         mask_a = vv.mask;
         run_a  = 1'b1;
         tick();
         for (int k = 0; k < int'(vv.nvis); k++) begin
            d = vv.seq[4*k +: 3];
            f = vv.fd[k];
            for (int c = 0; c < 4; c++) begin
               chk($sformatf("v%0d_show_k%0d_c%0d", v, k, c), {en_a, idx_a, fd_a},
                   {1'b1, d, (c == 0) ? f : 1'b0});
               tick();
            end
            for (int c = 0; c < 2; c++) begin
               chk($sformatf("v%0d_blank_k%0d_c%0d", v, k, c), {en_a, idx_a, fd_a}, {1'b0, d, 1'b0});
               tick();
            end
         end
      end

      // No gap, DIV=1: idx alternates every cycle, frame_done on each return to 0 after the start.
      mask_b = 8'h03;
      run_b  = 1'b1;
      tick();
      for (int c = 0; c < 8; c++) begin
         chk($sformatf("nogap_c%0d", c), {en_b, idx_b, fd_b},
             {1'b1, 3'(c % 2), (c >= 2 && (c % 2) == 0)});
         tick();
      end
      run_b = 1'b0;

      // Stop in the second SHOW cycle, then restart on a new mask with a full-length dwell.
      run_a = 1'b0;
      tick();
      mask_a = 8'hFF;
      run_a  = 1'b1;
      tick();
      chk("stop_show1", {en_a, idx_a, fd_a}, {1'b1, 3'd0, 1'b0});
      tick();
      chk("stop_show2", {en_a, idx_a, fd_a}, {1'b1, 3'd0, 1'b0});
      run_a = 1'b0;
      tick();
      chk("stop_idle", {en_a, idx_a, fd_a}, {1'b0, 3'd0, 1'b0});
      mask_a = 8'h0C;
      run_a  = 1'b1;
      tick();
      for (int c = 0; c < 4; c++) begin
         chk($sformatf("restart_show_c%0d", c), {en_a, idx_a, fd_a}, {1'b1, 3'd2, 1'b0});
         tick();
      end
      for (int c = 0; c < 2; c++) begin
         chk($sformatf("restart_blank_c%0d", c), {en_a, idx_a, fd_a}, {1'b0, 3'd2, 1'b0});
         tick();
      end
      chk("restart_next_digit", {en_a, idx_a, fd_a}, {1'b1, 3'd3, 1'b0});

      // Asynchronous reset mid-SHOW, checked before the next clock edge.
      rst_n = 1'b0;
      #1;
      chk("async_reset_a", {en_a, idx_a, fd_a}, 5'b0);
      chk("async_reset_b", {en_b, idx_b, fd_b}, 5'b0);
      #1;
      rst_n = 1'b1;
      tick();
      chk("resume_from_idle", {en_a, idx_a, fd_a}, {1'b1, 3'd2, 1'b0});

      // Mask drops to zero mid-dwell: dwell and gap still complete, then idle with idx held.
      mask_a = 8'h00;
      tick();
      for (int c = 0; c < 3; c++) begin
         chk($sformatf("mask0_show_c%0d", c), {en_a, idx_a, fd_a}, {1'b1, 3'd2, 1'b0});
         tick();
      end
      for (int c = 0; c < 2; c++) begin
         chk($sformatf("mask0_blank_c%0d", c), {en_a, idx_a, fd_a}, {1'b0, 3'd2, 1'b0});
         tick();
      end
      for (int c = 0; c < 3; c++) begin
         chk($sformatf("mask0_idle_c%0d", c), {en_a, idx_a, fd_a}, {1'b0, 3'd2, 1'b0});
         tick();
      end

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule
